// File: rtl/fifo_fill_pkg.sv
// Shared definitions for the FIFO fill controller: FSM state encoding,
// generator mode encodings and the LFSR tap constants.
package fifo_fill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Generator mode encodings; MODE_RSVD falls back to the constant pattern.
   localparam logic [1:0] MODE_CONST = 2'd0;
   localparam logic [1:0] MODE_INC   = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   // Fibonacci feedback masks (bit i set = stage i+1 tapped), maximal length.
   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;          // x^8+x^6+x^5+x^4+1
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1

   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      case (width)
         8:       return {24'd0, LFSR_TAPS_8};
         16:      return {16'd0, LFSR_TAPS_16};
         32:      return LFSR_TAPS_32;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic lfsr_width_ok(input int unsigned width);
      return (width == 8) || (width == 16) || (width == 32);
   endfunction

endpackage

// File: rtl/fifo_fill_datagen.sv
// Write-data generator for the FIFO fill controller. Holds the gen register
// and selects between the constant pattern, an incrementing count and (when
// FIFO_FILL_LFSR_EN is defined) a Fibonacci LFSR. gen only moves on accepted
// writes and is reloaded with the seed on reset or clear.
module fifo_fill_datagen
   import fifo_fill_pkg::*;
#(
   parameter int         DATA_W  = 8,
   parameter logic [7:0] PATTERN = 8'hAA
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              advance,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] data
);

   localparam logic [DATA_W-1:0] SEED = DATA_W'(PATTERN);

   logic [DATA_W-1:0] gen;
   logic [DATA_W-1:0] gen_next;

`ifdef FIFO_FILL_LFSR_EN
   generate
      if (!lfsr_width_ok(DATA_W)) begin : g_bad_lfsr_width
         $error("fifo_fill_datagen: LFSR supports DATA_W of 8, 16 or 32 only");
      end
   endgenerate

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

   // An all-zero register would lock the LFSR, so zero is read as 1.
   logic [DATA_W-1:0] lfsr_cur;
   assign lfsr_cur = (gen == '0) ? DATA_W'(1) : gen;

   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] cur);
      return {cur[DATA_W-2:0], ^(cur & TAPS)};
   endfunction
`endif

   // Mode mux: output word for this cycle and the value gen takes on a write.
   always_comb begin
      data     = SEED;
      gen_next = gen;
      case (mode)
         MODE_INC: begin
            data     = gen;
            gen_next = gen + DATA_W'(1);
         end
`ifdef FIFO_FILL_LFSR_EN
         MODE_LFSR: begin
            data     = lfsr_cur;
            gen_next = lfsr_step(lfsr_cur);
         end
`endif
         default: begin
            data     = SEED;
            gen_next = gen;
         end
      endcase
   end

   // gen register: seed on reset/clear, step only when a write is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         gen <= SEED;
      end else if (advance) begin
         gen <= gen_next;
      end
   end

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Producer-side FIFO fill controller with hysteresis. Writes generated data
// while the FIFO is below hi_mark, pauses until it drains to lo_mark, counts
// accepted writes and flags lo_mark >= hi_mark as a configuration error.
// Optional LFSR data mode is enabled by defining FIFO_FILL_LFSR_EN.
module fifo_fill_ctrl
   import fifo_fill_pkg::*;
#(
   parameter int         DATA_W  = 8,
   parameter int         COUNT_W = 4,
   parameter logic [7:0] PATTERN = 8'hAA,
   parameter int         WCNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic [COUNT_W-1:0] hi_mark,
   input  logic [COUNT_W-1:0] lo_mark,
   input  logic [COUNT_W-1:0] fifo_words,
   input  logic               fifo_full,
   output logic               wr_en,
   output logic [DATA_W-1:0]  fifo_data,
   output logic [WCNT_W-1:0]  wr_count,
   output logic               busy,
   output logic               cfg_err
);

   state_t state;
   logic   force_idle;

   // Illegal marks would make the hysteresis band empty or inverted.
   assign cfg_err    = (lo_mark >= hi_mark);
   assign force_idle = !enable || cfg_err;

   assign busy  = (state == FILL);
   assign wr_en = (state == FILL) && !fifo_full;

   // Hysteresis FSM: fill up to hi_mark, hold until drained to lo_mark.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (force_idle) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    state <= (fifo_words < hi_mark) ? FILL : HOLD;
            FILL:    if (fifo_words >= hi_mark) state <= HOLD;
            HOLD:    if (fifo_words <= lo_mark) state <= FILL;
            default: state <= IDLE;
         endcase
      end
   end

   // Statistics: accepted writes since reset, wrapping; enable does not clear it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_count <= '0;
      end else if (wr_en) begin
         wr_count <= wr_count + WCNT_W'(1);
      end
   end

   // Every path into IDLE passes through force_idle, so it doubles as the reseed.
   fifo_fill_datagen #(
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_datagen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (force_idle),
      .advance (wr_en),
      .mode    (mode),
      .data    (fifo_data)
   );

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl: reset, hysteresis, increment mode with
// wrap, backpressure, config error, reset during fill and the mode-2 path.
module tb_fifo_fill_ctrl;
   import fifo_fill_pkg::*;

   localparam int DATA_W  = 8;
   localparam int COUNT_W = 4;
   localparam int WCNT_W  = 16;

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic [1:0]         mode;
   logic [COUNT_W-1:0] hi_mark;
   logic [COUNT_W-1:0] lo_mark;
   logic [COUNT_W-1:0] fifo_words;
   logic               fifo_full;
   logic               wr_en;
   logic [DATA_W-1:0]  fifo_data;
   logic [WCNT_W-1:0]  wr_count;
   logic               busy;
   logic               cfg_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   fifo_fill_ctrl #(
      .DATA_W  (DATA_W),
      .COUNT_W (COUNT_W),
      .PATTERN (8'hAA),
      .WCNT_W  (WCNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .mode       (mode),
      .hi_mark    (hi_mark),
      .lo_mark    (lo_mark),
      .fifo_words (fifo_words),
      .fifo_full  (fifo_full),
      .wr_en      (wr_en),
      .fifo_data  (fifo_data),
      .wr_count   (wr_count),
      .busy       (busy),
      .cfg_err    (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reset, then release; the controller is in FILL when this returns.
   task automatic do_reset(input logic [COUNT_W-1:0] hi, input logic [COUNT_W-1:0] lo,
                           input logic [1:0] m);
      rst_n      = 1'b0;
      enable     = 1'b1;
      fifo_full  = 1'b0;
      fifo_words = '0;
      hi_mark    = hi;
      lo_mark    = lo;
      mode       = m;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; mode = MODE_CONST;
      hi_mark = 4'd5; lo_mark = 4'd2; fifo_words = 4'd0; fifo_full = 1'b0;
      step(); step(); step();
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd0) $display("FAIL reset_wr_count got %0d want 0", wr_count); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL reset_data got %02h want aa", fifo_data); else pass_cnt++;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %0b want 0", cfg_err); else pass_cnt++;
      rst_n = 1'b1;
      step();
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL release_wr_en got %0b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL release_busy got %0b want 1", busy); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd0) $display("FAIL release_wr_count got %0d want 0", wr_count); else pass_cnt++;
   endtask

   task automatic test_hysteresis();
      logic [COUNT_W-1:0] down [3];
      down[0] = 4'd5; down[1] = 4'd4; down[2] = 4'd3;
      do_reset(4'd5, 4'd2, MODE_CONST);
      for (int w = 0; w <= 5; w++) begin
         fifo_words = COUNT_W'(w);
         #1;
         total_cnt++; if (wr_en !== 1'b1) $display("FAIL hyst_ramp_wr_en words=%0d got %0b want 1", w, wr_en); else pass_cnt++;
         step();
      end
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL hyst_hold_wr_en got %0b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL hyst_hold_busy got %0b want 0", busy); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd6) $display("FAIL hyst_count got %0d want 6", wr_count); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         fifo_words = down[k];
         step();
         total_cnt++; if (wr_en !== 1'b0) $display("FAIL hyst_drain_wr_en words=%0d got %0b want 0", down[k], wr_en); else pass_cnt++;
      end
      fifo_words = 4'd2;
      #1;
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL hyst_lo_same_cycle got %0b want 0", wr_en); else pass_cnt++;
      step();
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL hyst_resume_wr_en got %0b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd6) $display("FAIL hyst_resume_count got %0d want 6", wr_count); else pass_cnt++;
   endtask

   task automatic test_increment();
      logic [7:0] exp;
      do_reset(4'd15, 4'd2, MODE_INC);
      for (int i = 0; i < 10; i++) begin
         exp = 8'hAA + 8'(i);
         total_cnt++; if (fifo_data !== exp) $display("FAIL inc_data i=%0d got %02h want %02h", i, fifo_data, exp); else pass_cnt++;
         step();
      end
      total_cnt++; if (wr_count !== 16'd10) $display("FAIL inc_count got %0d want 10", wr_count); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'hB4) $display("FAIL inc_data_after10 got %02h want b4", fifo_data); else pass_cnt++;
      for (int i = 0; i < 8'h56; i++) begin
         exp = 8'hB4 + 8'(i);
         total_cnt++; if (fifo_data !== exp) $display("FAIL inc_wrap_data i=%0d got %02h want %02h", i, fifo_data, exp); else pass_cnt++;
         step();
      end
      total_cnt++; if (fifo_data !== 8'h0A) $display("FAIL inc_after_wrap got %02h want 0a", fifo_data); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd96) $display("FAIL inc_wrap_count got %0d want 96", wr_count); else pass_cnt++;
      mode = MODE_CONST;
      #1;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL const_mode_data got %02h want aa", fifo_data); else pass_cnt++;
      mode = MODE_RSVD;
      #1;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL rsvd_mode_data got %02h want aa", fifo_data); else pass_cnt++;
      step();
      mode = MODE_INC;
      #1;
      total_cnt++; if (fifo_data !== 8'h0A) $display("FAIL inc_resume_no_reseed got %02h want 0a", fifo_data); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd97) $display("FAIL const_write_count got %0d want 97", wr_count); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset(4'd15, 4'd2, MODE_INC);
      step(); step();
      fifo_full = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         total_cnt++; if (wr_en !== 1'b0) $display("FAIL bp_wr_en cycle=%0d got %0b want 0", c, wr_en); else pass_cnt++;
         total_cnt++; if (busy !== 1'b1) $display("FAIL bp_busy cycle=%0d got %0b want 1", c, busy); else pass_cnt++;
         total_cnt++; if (fifo_data !== 8'hAC) $display("FAIL bp_data cycle=%0d got %02h want ac", c, fifo_data); else pass_cnt++;
         step();
      end
      fifo_full = 1'b0;
      #1;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL bp_release_wr_en got %0b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd2) $display("FAIL bp_count got %0d want 2", wr_count); else pass_cnt++;
      step();
      total_cnt++; if (fifo_data !== 8'hAD) $display("FAIL bp_after_data got %02h want ad", fifo_data); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd3) $display("FAIL bp_after_count got %0d want 3", wr_count); else pass_cnt++;
   endtask

   task automatic test_cfg_err();
      do_reset(4'd15, 4'd2, MODE_INC);
      step(); step(); step();
      hi_mark = 4'd3; lo_mark = 4'd3;
      #1;
      total_cnt++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_set got %0b want 1", cfg_err); else pass_cnt++;
      step();
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL cfg_idle_wr_en got %0b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL cfg_idle_busy got %0b want 0", busy); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL cfg_reseed got %02h want aa", fifo_data); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd4) $display("FAIL cfg_count got %0d want 4", wr_count); else pass_cnt++;
      step();
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL cfg_stay_idle got %0b want 0", wr_en); else pass_cnt++;
      lo_mark = 4'd1;
      #1;
      total_cnt++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear got %0b want 0", cfg_err); else pass_cnt++;
      step();
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL cfg_resume_wr_en got %0b want 1", wr_en); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL cfg_resume_data got %02h want aa", fifo_data); else pass_cnt++;
      enable = 1'b0;
      step();
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL disable_wr_en got %0b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd5) $display("FAIL disable_count got %0d want 5", wr_count); else pass_cnt++;
      step();
      total_cnt++; if (wr_count !== 16'd5) $display("FAIL disable_count_kept got %0d want 5", wr_count); else pass_cnt++;
      enable = 1'b1;
   endtask

   task automatic test_reset_mid_fill();
      do_reset(4'd15, 4'd2, MODE_INC);
      step(); step();
      rst_n = 1'b0;
      #1;
      total_cnt++; if (wr_en !== 1'b1) $display("FAIL midrst_before_edge got %0b want 1", wr_en); else pass_cnt++;
      step();
      total_cnt++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en got %0b want 0", wr_en); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd0) $display("FAIL midrst_count got %0d want 0", wr_count); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL midrst_data got %02h want aa", fifo_data); else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_lfsr();
`ifdef FIFO_FILL_LFSR_EN
      logic       seen [256];
      logic [7:0] first;
      logic [7:0] v;
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      first = 8'h00;
      do_reset(4'd15, 4'd2, MODE_LFSR);
      for (int i = 0; i < 255; i++) begin
         v = fifo_data;
         if (i == 0) first = v;
         total_cnt++; if (v === 8'h00) $display("FAIL lfsr_zero i=%0d got %02h want nonzero", i, v); else pass_cnt++;
         total_cnt++; if (seen[v] !== 1'b0) $display("FAIL lfsr_repeat i=%0d got %02h want unseen", i, v); else pass_cnt++;
         seen[v] = 1'b1;
         step();
      end
      total_cnt++; if (first !== 8'hAA) $display("FAIL lfsr_seed got %02h want aa", first); else pass_cnt++;
      total_cnt++; if (fifo_data !== first) $display("FAIL lfsr_period got %02h want %02h", fifo_data, first); else pass_cnt++;
      total_cnt++; if (wr_count !== 16'd255) $display("FAIL lfsr_count got %0d want 255", wr_count); else pass_cnt++;
`else
      do_reset(4'd15, 4'd2, MODE_LFSR);
      for (int i = 0; i < 8; i++) begin
         total_cnt++; if (fifo_data !== 8'hAA) $display("FAIL mode2_const i=%0d got %02h want aa", i, fifo_data); else pass_cnt++;
         step();
      end
      total_cnt++; if (wr_count !== 16'd8) $display("FAIL mode2_count got %0d want 8", wr_count); else pass_cnt++;
`endif
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; mode = MODE_CONST;
      hi_mark = '0; lo_mark = '0; fifo_words = '0; fifo_full = 1'b0;
      test_reset();
      test_hysteresis();
      test_increment();
      test_backpressure();
      test_cfg_err();
      test_reset_mid_fill();
      test_lfsr();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
